// File: rtl/tetris_pkg.sv
// tetris_pkg: shared direction type and default timing constants for the tetris blocks
package tetris_pkg;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
  localparam int CLK_HZ = 50_000_000;
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;
  localparam int GRAVITY_SLOW_CYCLES = 40_000_002;
endpackage

// File: rtl/tetris_debounce.sv
// tetris_debounce: 2-FF synchronizer + debouncer; raw in, stable level plus one-cycle rise/fall strobes out
module tetris_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      cnt <= '0;
      stable <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        stable <= sync[1];
        rise <= sync[1];
        fall <= ~sync[1];
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: raw btn_left/right/down/rotate + game_over in; move_left/right (stretched), move_down (level), rotate (pulse) out
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES = GRAVITY_SLOW_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic game_over,
  output logic move_left,
  output logic move_right,
  output logic move_down,
  output logic rotate
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [3:0] raw, stable, rise, fall;
  dir_t dir, dir_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  assign raw = {btn_rotate, btn_down, btn_right, btn_left};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_db
    tetris_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset_n(reset_n),
      .raw(raw[i]),
      .stable(stable[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dir <= DIR_NONE;
      hcnt <= '0;
      move_down <= 1'b0;
      rotate <= 1'b0;
    end else begin
      dir <= dir_nxt;
      hcnt <= hcnt_nxt;
      move_down <= stable[2] & ~game_over;
      rotate <= rise[3] & ~game_over;
    end
  // left is tested first so a simultaneous left/right rise goes left
  always_comb begin
    dir_nxt = dir;
    hcnt_nxt = (hcnt == '0) ? '0 : hcnt - 1'b1;
    if (game_over) begin
      dir_nxt = DIR_NONE;
      hcnt_nxt = '0;
    end else if (rise[0]) begin
      dir_nxt = DIR_LEFT;
      hcnt_nxt = HW'(HOLD_CYCLES);
    end else if (rise[1]) begin
      dir_nxt = DIR_RIGHT;
      hcnt_nxt = HW'(HOLD_CYCLES);
    end else if (hcnt == '0 && ((dir == DIR_LEFT && !stable[0]) || (dir == DIR_RIGHT && !stable[1])))
      dir_nxt = DIR_NONE;
  end
  always_comb begin
    move_left = (dir == DIR_LEFT);
    move_right = (dir == DIR_RIGHT);
  end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: scoreboard bench for tetris_input_ctrl with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20
module tb_tetris_input_ctrl;
  localparam int D = 4;
  localparam int H = 20;
  typedef struct {
    int cyc;
    logic [3:0] v;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rotate = 1'b0, game_over = 1'b0;
  logic move_left, move_right, move_down, rotate;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int n;
  exp_t q[$];
  exp_t e;
  tetris_input_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_down(btn_down),
    .btn_rotate(btn_rotate),
    .game_over(game_over),
    .move_left(move_left),
    .move_right(move_right),
    .move_down(move_down),
    .rotate(rotate)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(string tag, logic [3:0] got, logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got {L,R,D,ROT}=%b, expected %b", tag, cyc, got, want);
    end
  endtask
  task automatic expect_range(int a, int b, logic [3:0] v, string tag);
    for (int c = a; c <= b; c++) q.push_back('{c, v, tag});
  endtask
  task automatic ticks(int k);
    repeat (k) @(negedge clk);
  endtask
  always @(negedge clk) begin
    check("excl", {3'b000, move_left & move_right}, 4'b0000);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check(e.tag, {move_left, move_right, move_down, rotate}, e.v);
    end
  end
  initial begin
    ticks(3);
    reset_n = 1'b1;
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "reset");
    ticks(10);
    n = cyc + 1;
    expect_range(n, n + 12, 4'b0000, "glitch1");
    btn_left = 1'b1; ticks(1); btn_left = 1'b0;
    ticks(15);
    n = cyc + 1;
    expect_range(n, n + 12, 4'b0000, "glitch3");
    btn_left = 1'b1; ticks(3); btn_left = 1'b0;
    ticks(15);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "tap_pre");
    expect_range(n + 6, n + 26, 4'b1000, "tap_hold");
    expect_range(n + 27, n + 30, 4'b0000, "tap_end");
    btn_left = 1'b1; ticks(4); btn_left = 1'b0;
    ticks(35);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "held_pre");
    expect_range(n + 6, n + 105, 4'b1000, "held");
    expect_range(n + 106, n + 110, 4'b0000, "held_end");
    btn_left = 1'b1; ticks(100); btn_left = 1'b0;
    ticks(15);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "lr_pre");
    expect_range(n + 6, n + 35, 4'b1000, "lr_left");
    expect_range(n + 36, n + 65, 4'b0100, "lr_right");
    expect_range(n + 66, n + 70, 4'b0000, "lr_end");
    btn_left = 1'b1; ticks(30);
    btn_right = 1'b1; ticks(30);
    btn_left = 1'b0; btn_right = 1'b0;
    ticks(20);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "simul_pre");
    expect_range(n + 6, n + 26, 4'b1000, "simul");
    expect_range(n + 27, n + 30, 4'b0000, "simul_end");
    btn_left = 1'b1; btn_right = 1'b1; ticks(10);
    btn_left = 1'b0; btn_right = 1'b0;
    ticks(30);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "down_pre");
    expect_range(n + 6, n + 15, 4'b0010, "down");
    expect_range(n + 16, n + 18, 4'b0000, "down_end");
    btn_down = 1'b1; ticks(10); btn_down = 1'b0;
    ticks(15);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "rot_pre");
    expect_range(n + 6, n + 6, 4'b0001, "rot_pulse");
    expect_range(n + 7, n + 230, 4'b0000, "rot_quiet");
    btn_rotate = 1'b1; ticks(200);
    btn_rotate = 1'b0; ticks(2);
    btn_rotate = 1'b1; ticks(2);
    btn_rotate = 1'b0; ticks(2);
    btn_rotate = 1'b1; ticks(2);
    btn_rotate = 1'b0;
    ticks(30);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "go_pre");
    expect_range(n + 6, n + 10, 4'b1010, "go_live");
    expect_range(n + 11, n + 20, 4'b0000, "go_frozen");
    expect_range(n + 21, n + 46, 4'b0010, "go_resume");
    expect_range(n + 47, n + 50, 4'b0000, "go_end");
    btn_left = 1'b1; btn_down = 1'b1; ticks(11);
    game_over = 1'b1; ticks(10);
    game_over = 1'b0; ticks(20);
    btn_left = 1'b0; btn_down = 1'b0;
    ticks(15);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "rst_pre");
    expect_range(n + 6, n + 9, 4'b1000, "rst_hold");
    btn_left = 1'b1; ticks(4); btn_left = 1'b0;
    ticks(6);
    reset_n = 1'b0;
    #1 check("async_rst", {move_left, move_right, move_down, rotate}, 4'b0000);
    ticks(3);
    reset_n = 1'b1;
    n = cyc + 1;
    expect_range(n, n + 30, 4'b0000, "post_rst");
    ticks(32);
    n = cyc + 1;
    expect_range(n, n + 5, 4'b0000, "repress_pre");
    expect_range(n + 6, n + 26, 4'b1000, "repress");
    expect_range(n + 27, n + 28, 4'b0000, "repress_end");
    btn_left = 1'b1; ticks(4); btn_left = 1'b0;
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
